// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] DEF_PAT     = 8'b0001_1011;
  localparam int         DEF_LEN     = 6;
  localparam logic       DEF_OVERLAP = 1'b1;
  localparam int         DEF_TARGET  = 5;

endpackage

// File: rtl/seq_det_if.sv
// Config, control, serial input and status bundle between the system logic and the detector.
interface seq_det_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) ();

  logic             in;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             stop;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output in, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, stop,
    input  y, match_count, busy, done, cfg_err
  );

  modport slave (
    input  in, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, stop,
    output y, match_count, busy, done, cfg_err
  );

endinterface

// File: rtl/seq_det_match.sv
// History shift register, fill counter and length-masked pattern compare.
// hit is combinational: it flags that the bit being sampled on this edge completes a match.
module seq_det_match #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  logic [PAT_W-1:0] history_q, history_d, history_nx, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_nx;

  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (32'(len) > 32'(gi));
    end
  endgenerate

  always_comb begin
    history_nx = {history_q[PAT_W-2:0], in_bit};
    fill_nx    = (fill_q >= len) ? len : fill_q + LEN_W'(1);
    hit        = active && (fill_nx == len) && (((history_nx ^ pattern) & mask) == '0);
    history_d  = history_q;
    fill_d     = fill_q;
    if (clear) begin
      history_d = '0;
      fill_d    = '0;
    end else if (active) begin
      history_d = history_nx;
      // Without overlap the next match must be built from len fresh bits.
      fill_d    = (hit && !overlap) ? '0 : fill_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence-detector controller: run FSM, config registers, match counter and registered outputs.
module seq_det_ctrl #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
  parameter int               DEF_LEN = seq_det_pkg::DEF_LEN
) (
  input  logic     clk,
  input  logic     reset,
  seq_det_if.slave bus
);

  import seq_det_pkg::*;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             y_q, y_d;
  logic             err_q, err_d;
  logic             clear, active, hit, cfg_bad;

  seq_det_match #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_match (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .active  (active),
    .in_bit  (bus.in),
    .overlap (ovl_q),
    .len     (len_q),
    .pattern (pat_q),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    count_d = count_q;
    y_d     = 1'b0;
    err_d   = 1'b0;
    clear   = 1'b0;
    active  = 1'b0;
    cfg_bad = (bus.cfg_len == '0) || (32'(bus.cfg_len) > PAT_W);

    if (bus.cfg_we) begin
      if (state_q == RUN || cfg_bad) begin
        err_d = 1'b1;
      end else begin
        pat_d = bus.cfg_pattern;
        len_d = bus.cfg_len;
        ovl_d = bus.cfg_overlap;
        tgt_d = bus.cfg_target;
      end
    end

    case (state_q)
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          active = 1'b1;
          if (hit) begin
            y_d = 1'b1;
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            if (tgt_q != '0 && count_d == tgt_q) state_d = DONE;
          end
        end
      end
      default: begin
        // stop beats start when both arrive together.
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
          clear   = 1'b1;
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      tgt_q   <= CNT_W'(DEF_TARGET);
      count_q <= '0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      count_q <= count_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.match_count = count_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.cfg_err     = err_q;

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial sequence-detector controller for the single-bit `in` stream, with Moore-style outputs.
- Holds a loadable pattern and length (default 011011, len 6) and an overlap mode.
- Sequences runs with start/stop, counts matches and raises `done` after a programmable number of matches.
- Sits between the system config/control logic and the serial input line, replacing hard-coded fixed-pattern detectors.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of cfg_len (must hold PAT_W)
CNT_W, 8, width of match counter and target
DEF_PAT, 8'b0001_1011, reset pattern (LSB = last bit received)
DEF_LEN, 6, reset pattern length

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in  input  1  serial data bit, sampled every clk edge while RUN
cfg_we  input  1  load config strobe
cfg_pattern  input  PAT_W  pattern; bit 0 = most recent bit
cfg_len  input  LEN_W  active pattern length, 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches until done; 0 = unlimited
start  input  1  begin a run
stop  input  1  abort a run
y  output  1  match pulse (registered, Moore)
match_count  output  CNT_W  matches in current/last run
busy  output  1  high in RUN
done  output  1  high in DONE
cfg_err  output  1  one-cycle pulse on rejected config

Behaviour:
- Reset values:
  - state IDLE; y, busy, done, cfg_err = 0; match_count = 0; history = 0; fill = 0.
  - config = DEF_PAT / DEF_LEN / overlap 1 / target 5.
- Reset asserted mid-run forces all of the above immediately; no partial state survives.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; match_count reaching nonzero target -> DONE.
  - DONE: start -> RUN; stop -> IDLE.
- If start and stop are asserted in the same cycle, stop wins.
- Entering RUN clears history, fill and match_count on that edge. `in` is first sampled on the next edge.
- RUN, every edge:
  - history <= {history[PAT_W-2:0], in}.
  - fill <= min(fill+1, cfg_len).
- Match condition: (fill_next == len) && (history_next[len-1:0] == pattern[len-1:0]).
- y is registered: high for exactly the one cycle after the edge that sampled the completing bit. y is 0 outside RUN, except for the final match pulse that coincides with the RUN->DONE transition.
- On match:
  - match_count increments, saturating at 2^CNT_W-1.
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
  - overlap=1: fill is held at len.
- DONE is entered on the same edge as the final match. done stays high until start or stop.
- target = 0: DONE is never entered, and the count saturates.
- stop preserves match_count for readback. Counts are cleared only by start.
- Config handling:
  - Accepted only in IDLE or DONE. It takes effect on the next edge and applies to the next run.
  - cfg_we in RUN is ignored and pulses cfg_err.
  - cfg_len = 0 or > PAT_W is rejected: cfg_err pulses and the old config is kept.
  - cfg_we together with start in IDLE: config loads first, and the run uses the new config.
- busy = (state == RUN).

Decomposition:
- Package seq_det_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default constants DEF_PAT, DEF_LEN, DEF_OVERLAP = 1, DEF_TARGET = 5.
- One sub-module, seq_det_match, holds the history shift register, the fill counter and the masked compare. It outputs a combinational `hit`.
- The FSM, config registers, counter and output registers live in the top level.

Test Plan:
1. Default config, overlap=1, target=0; start, then drive 011011 five times (30 bits, one per clk) -> 9 y pulses after bits 6,9,12,...,30; match_count = 9; done = 0.
2. Same stream with overlap=0 loaded in IDLE -> 5 y pulses after bits 6,12,18,24,30; match_count = 5.
3. overlap=1, target=5, same stream -> DONE entered on bit 18; done = 1; match_count = 5; busy = 0; later bits give no y.
4. Load pattern 101, len 3 in IDLE; then stream 10101 -> y after bits 3 and 5 with overlap=1; cfg_len = 0 -> cfg_err pulses once, config unchanged.
5. cfg_we during RUN -> cfg_err one-cycle pulse, matching continues on the old pattern. start and stop in the same cycle from RUN -> IDLE, count retained.
6. Assert reset asynchronously mid-run, between clk edges, after 2 matches -> all outputs 0 immediately, config back to defaults; a new start counts from 0.
